// File: rtl/aha_clock_switch_ctrl.sv
// Break-before-make sequencer for NUM_CLKS glitch-free clock switch slices.
// Drops the current slice select, waits for every slice ack to clear, then raises the target select.
module aha_clock_switch_ctrl #(
    parameter int NUM_CLKS    = 4,
    parameter int SEL_W       = 2,
    parameter int DEFAULT_SEL = 0,
    parameter int TIMEOUT     = 255
) (
    input  logic                clk_i,
    input  logic                reset_i,
    input  logic                req_valid_i,
    input  logic [SEL_W-1:0]    req_sel_i,
    output logic                req_ready_o,
    input  logic [NUM_CLKS-1:0] slice_ack_i,
    output logic [NUM_CLKS-1:0] select_req_o,
    output logic [SEL_W-1:0]    cur_sel_o,
    output logic                busy_o,
    output logic                done_o,
    output logic                err_o,
    input  logic                err_clr_i
);

    // state | meaning
    // INIT  | default slice selected out of reset, waiting for its ack
    // IDLE  | stable, accepting requests
    // DESEL | all selects low, waiting for every ack to clear
    // SEL   | target select high, waiting for its ack
    // FAIL  | one-cycle landing state after a wait timeout
    typedef enum logic [2:0] {S_INIT, S_IDLE, S_DESEL, S_SEL, S_FAIL} state_t;

    localparam logic [SEL_W-1:0]    DEF_IDX   = SEL_W'(DEFAULT_SEL);
    localparam logic [15:0]         WAIT_LAST = 16'(TIMEOUT - 1);
    localparam int                  IDX_SPAN  = 2 ** SEL_W;
    localparam logic [IDX_SPAN-1:0] IDX_OK    = IDX_SPAN'((64'd1 << NUM_CLKS) - 64'd1);

    function automatic logic [NUM_CLKS-1:0] onehot(input logic [SEL_W-1:0] idx);
        return NUM_CLKS'(1) << idx;
    endfunction

    state_t              state_q;
    logic [NUM_CLKS-1:0] sel_req_q;
    logic [SEL_W-1:0]    cur_sel_q;
    logic [SEL_W-1:0]    tgt_q;
    logic [15:0]         wait_q;
    logic [15:0]         wait_d;
    logic                done_q;
    logic                err_q;
    logic [NUM_CLKS-1:0] ack_m_q;
    logic [NUM_CLKS-1:0] ack_s_q;

    assign wait_d = wait_q + 16'd1;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q   <= S_INIT;
            sel_req_q <= onehot(DEF_IDX);
            cur_sel_q <= DEF_IDX;
            tgt_q     <= DEF_IDX;
            wait_q    <= '0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            ack_m_q   <= '0;
            ack_s_q   <= '0;
        end else begin
            ack_m_q <= slice_ack_i;
            ack_s_q <= ack_m_q;
            done_q  <= 1'b0;
            // Later error sets in this block override the clear.
            if (err_clr_i) err_q <= 1'b0;
            unique case (state_q)
                S_INIT: begin
                    if (ack_s_q[DEF_IDX]) begin
                        state_q   <= S_IDLE;
                        cur_sel_q <= DEF_IDX;
                        done_q    <= 1'b1;
                    end else if (wait_q == WAIT_LAST) begin
                        state_q <= S_FAIL;
                        err_q   <= 1'b1;
                    end else begin
                        wait_q <= wait_d;
                    end
                end
                S_IDLE: begin
                    if (req_valid_i) begin
                        if (!IDX_OK[req_sel_i]) begin
                            err_q <= 1'b1;
                        end else if (req_sel_i == cur_sel_q) begin
                            done_q <= 1'b1;
                        end else begin
                            tgt_q     <= req_sel_i;
                            sel_req_q <= '0;
                            wait_q    <= '0;
                            state_q   <= S_DESEL;
                        end
                    end
                end
                S_DESEL: begin
                    if (ack_s_q == '0) begin
                        state_q   <= S_SEL;
                        sel_req_q <= onehot(tgt_q);
                        wait_q    <= '0;
                    end else if (wait_q == WAIT_LAST) begin
                        state_q <= S_FAIL;
                        err_q   <= 1'b1;
                    end else begin
                        wait_q <= wait_d;
                    end
                end
                S_SEL: begin
                    if (ack_s_q[tgt_q]) begin
                        state_q   <= S_IDLE;
                        cur_sel_q <= tgt_q;
                        done_q    <= 1'b1;
                    end else if (wait_q == WAIT_LAST) begin
                        state_q <= S_FAIL;
                        err_q   <= 1'b1;
                    end else begin
                        wait_q <= wait_d;
                    end
                end
                S_FAIL: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_INIT;
                end
            endcase
        end
    end

    assign req_ready_o  = (state_q == S_IDLE);
    assign busy_o       = (state_q != S_IDLE);
    assign select_req_o = sel_req_q;
    assign cur_sel_o    = cur_sel_q;
    assign done_o       = done_q;
    assign err_o        = err_q;

endmodule
